bram_burst_wr: RTL
==================

Name: bram_burst_wr

Overview:
- Write-side counterpart of the BRAM base-address reader: drives a Xilinx BRAM controller native port as master and writes a burst of NUM_WORDS 32-bit words.
- Writes go to consecutive word addresses starting at START_ADDR.
- Accepts data from an upstream valid/ready stream, e.g. accelerator results or a descriptor table for the PS.
- Raises a level Transfer_Done once the last write strobe has been issued to the BRAM port.

Parameters:
- START_ADDR, 32'h4580_0000, byte address of the first word written.
- NUM_WORDS, 16, words per burst; legal range 1..65535.
- CNT_W, 16, width of the internal beat counter; must satisfy 2**CNT_W > NUM_WORDS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  one-cycle pulse that begins a burst; honoured only in IDLE or DONE.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block accepts a word this cycle.
- s_data  input  32  upstream word.
- ram_clk  output  1  driven directly by clk.
- ram_rst  output  1  tied 1'b0.
- ram_addr  output  32  registered BRAM byte address.
- ram_en  output  1  registered BRAM enable.
- ram_we  output  4  registered byte write enables.
- ram_wd_data  output  32  registered write data.
- ram_rd_data  input  32  unused; present for port completeness.
- Transfer_Done  output  1  level, high while in DONE.

Behaviour:
Reset:
- Reset is synchronous and active-low. When rst_n=0 at a clk edge: state=IDLE, beat counter=0, ram_addr=0, ram_en=0, ram_we=0, ram_wd_data=0, Transfer_Done=0, s_ready=0.
- Reset mid-burst abandons the burst. No further strobes are issued, and the next cycle is IDLE.

FSM states: IDLE, WRITE, DONE.
- IDLE: s_ready=0. start=1 -> WRITE; counter cleared to 0.
- WRITE: s_ready=1 (combinational from state only). start is ignored. A beat is accepted when s_valid && s_ready.
- DONE: Transfer_Done=1 and s_ready=0. Stays in DONE until start=1 -> WRITE with counter=0; Transfer_Done drops in that same next cycle.

Accepted beat k (counter=k):
- Next cycle: ram_en=1, ram_we=4'hF, ram_addr=START_ADDR+(k<<2) (32-bit add, wraps mod 2**32), ram_wd_data=s_data. Write latency is exactly one cycle from the handshake.
- counter <= k+1.
- If k==NUM_WORDS-1, state -> DONE in the same edge.

Write strobes:
- In any cycle following a non-accepted cycle, ram_en=0 and ram_we=0.
- ram_addr and ram_wd_data hold their last values.
- Strobes are single-cycle per beat; back-to-back beats give back-to-back strobes with no bubbles.

Transfer_Done timing:
- Transfer_Done rises on the same edge that presents the final write strobe to the BRAM.
- Done is therefore visible in the same cycle the last word is written.

Boundary conditions:
- s_valid low in WRITE: the block waits indefinitely. No timeout.
- NUM_WORDS=1: a single beat takes the block to DONE.
- start asserted on the same edge as the last beat: ignored, because the state at that edge is WRITE.
- Data presented while in IDLE or DONE is not consumed (s_ready=0).

Test Plan:
1. rst_n=0 for 3 cycles with start and s_valid toggling -> all outputs 0 and s_ready=0. After release, idle outputs stay 0 until start.
2. start pulse, then s_valid=1 continuously with s_data=32'h100+k, NUM_WORDS=16 -> 16 consecutive strobes:
   - ram_addr=32'h4580_0000..32'h4580_003C in steps of 4.
   - ram_wd_data=32'h100..32'h10F, ram_we=4'hF.
   - Transfer_Done rises with the 16th strobe; s_ready low the cycle after.
3. Same as 2 but s_valid deasserted on every odd cycle:
   - Strobes occur only in the cycle after each handshake, and ram_en is 0 in the gap cycles.
   - Addresses are still contiguous; Transfer_Done occurs after the 16th accepted beat.
4. start pulsed again mid-burst after 5 beats -> ignored. Counter continues at 5, and the burst completes with 16 writes total.
5. rst_n=0 for 1 cycle after 7 beats -> no further strobes and state IDLE. A new start writes from 32'h4580_0000 again.
6. In DONE, start pulse -> Transfer_Done falls the next cycle, s_ready=1, and the next burst begins at START_ADDR.
   - NUM_WORDS=1 variant: one strobe at START_ADDR, with Transfer_Done high on that same cycle.

Source files
------------

// File: rtl/bram_burst_wr_if.sv
// bram_burst_wr_if: upstream stream, start/done and BRAM native port bundle.
// The master view belongs to the block that drives the BRAM port.
interface bram_burst_wr_if;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        ram_clk;
    logic        ram_rst;
    logic [31:0] ram_addr;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_wd_data;
    logic [31:0] ram_rd_data;
    logic        Transfer_Done;
    modport master (
        input  start, s_valid, s_data, ram_rd_data,
        output s_ready, ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data, Transfer_Done
    );
    modport slave (
        output start, s_valid, s_data, ram_rd_data,
        input  s_ready, ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data, Transfer_Done
    );
endinterface

// File: rtl/bram_burst_wr.sv
// bram_burst_wr: writes a burst of NUM_WORDS stream words to consecutive BRAM
// word addresses from START_ADDR, raising Transfer_Done with the final strobe.
module bram_burst_wr #(
    parameter logic [31:0] START_ADDR = 32'h4580_0000,
    parameter int          NUM_WORDS  = 16,
    parameter int          CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    bram_burst_wr_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en;
    logic [3:0]       r_we;
    logic [31:0]      r_addr, r_data;
    logic             w_accept, w_start, w_last;
    assign w_accept = bus.s_valid && (r_state == WRITE);
    assign w_start  = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_last   = r_cnt == CNT_W'(NUM_WORDS - 1);
    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = WRITE;
        else if (w_accept && w_last)
            w_next = DONE;
    end
    // Strobe, address and data are registered so the write lands one cycle after the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_we    <= 4'h0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_start ? '0 : w_accept ? r_cnt + CNT_W'(1) : r_cnt;
            r_en    <= w_accept;
            r_we    <= w_accept ? 4'hF : 4'h0;
            if (w_accept) begin
                r_addr <= START_ADDR + (32'(r_cnt) << 2);
                r_data <= bus.s_data;
            end
        end
    end
    assign bus.s_ready       = r_state == WRITE;
    assign bus.Transfer_Done = r_state == DONE;
    assign bus.ram_clk       = clk;
    assign bus.ram_rst       = 1'b0;
    assign bus.ram_addr      = r_addr;
    assign bus.ram_en        = r_en;
    assign bus.ram_we        = r_we;
    assign bus.ram_wd_data   = r_data;
endmodule
